// File: rtl/gshare_bpu_pkg.sv
// ============================================================================
// gshare_bpu_pkg : shared constants and helpers for the gshare predictor
// Revision 1.0
// ============================================================================
`default_nettype none

package gshare_bpu_pkg;

  localparam logic [1:0] FLUSH_NONE = 2'b00;
  localparam logic [1:0] FLUSH_IF   = 2'b01;
  localparam logic [1:0] FLUSH_ALL  = 2'b11;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Weakly-not-taken: MSB clear, all lower bits set.
  function automatic int unsigned wnt(input int unsigned ctr_bits);
    return (32'd1 << (ctr_bits - 32'd1)) - 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gshare_bpu_if.sv
// ============================================================================
// gshare_bpu_if : ID prediction, MEM resolve and redirect signals of the BPU
// Revision 1.0
// ============================================================================
`default_nettype none

interface gshare_bpu_if #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 3,
  parameter int GHR_BITS = 3
);
  logic                jump_early;
  logic                branch_early;
  logic [XLEN-1:0]     pc;
  logic [XLEN-1:0]     immID;
  logic                branch_resolved;
  logic                actual_taken;
  logic [IDX_BITS-1:0] pht_indexMEM;
  logic [GHR_BITS-1:0] ghr_ckptMEM;
  logic                pred_takenMEM;
  logic [XLEN-1:0]     pcMEM;
  logic [XLEN-1:0]     targetMEM;
  logic [XLEN-1:0]     PC_Jump;
  logic                jump_taken;
  logic [1:0]          flush;
  logic [IDX_BITS-1:0] pht_index;
  logic [GHR_BITS-1:0] ghr_ckpt;
  logic                init_busy;

  modport master (
    output jump_early, branch_early, pc, immID, branch_resolved, actual_taken,
           pht_indexMEM, ghr_ckptMEM, pred_takenMEM, pcMEM, targetMEM,
    input  PC_Jump, jump_taken, flush, pht_index, ghr_ckpt, init_busy
  );

  modport slave (
    input  jump_early, branch_early, pc, immID, branch_resolved, actual_taken,
           pht_indexMEM, ghr_ckptMEM, pred_takenMEM, pcMEM, targetMEM,
    output PC_Jump, jump_taken, flush, pht_index, ghr_ckpt, init_busy
  );
endinterface

`default_nettype wire

// File: rtl/gshare_bpu_sat_counter.sv
// ============================================================================
// gshare_bpu_sat_counter : next value of a saturating up/down counter
// Revision 1.0
// ============================================================================
`default_nettype none

module gshare_bpu_sat_counter #(
  parameter int CTR_BITS = 2
) (
  input  wire logic [CTR_BITS-1:0] i_ctr,
  input  wire logic                i_up,
  output logic      [CTR_BITS-1:0] o_ctr
);
  localparam logic [CTR_BITS-1:0] c_MAX = '1;
  localparam logic [CTR_BITS-1:0] c_MIN = '0;

  always_comb begin
    o_ctr = i_ctr;
    if (i_up) begin
      if (i_ctr != c_MAX) o_ctr = i_ctr + 1'b1;
    end else begin
      if (i_ctr != c_MIN) o_ctr = i_ctr - 1'b1;
    end
  end
endmodule

`default_nettype wire

// File: rtl/gshare_bpu.sv
// ============================================================================
// gshare_bpu : gshare branch predictor with speculative GHR, checkpoint
//              recovery and a post-reset PHT init sweep
// Revision 1.0
// ============================================================================
`default_nettype none

module gshare_bpu
  import gshare_bpu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 3,
  parameter int GHR_BITS = 3,
  parameter int CTR_BITS = 2
) (
  input wire logic    clk,
  input wire logic    rst_n,
  gshare_bpu_if.slave bus
);
  localparam int                  c_DEPTH = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] c_WNT   = CTR_BITS'(wnt(CTR_BITS));
  localparam logic [IDX_BITS-1:0] c_LAST  = {IDX_BITS{1'b1}};

  logic [CTR_BITS-1:0] r_pht [c_DEPTH];
  logic [GHR_BITS-1:0] r_ghr;
  logic [0:0]          r_state;
  logic [IDX_BITS-1:0] r_init_cnt;

  logic                w_run;
  logic [IDX_BITS-1:0] w_idx;
  logic                w_pred;
  logic                w_mispred;
  logic                w_spec_shift;
  logic [GHR_BITS-1:0] w_ghr_spec;
  logic [GHR_BITS-1:0] w_ghr_fix;
  logic [CTR_BITS-1:0] w_trained;
  logic                w_we;
  logic [IDX_BITS-1:0] w_waddr;
  logic [CTR_BITS-1:0] w_wdata;

  assign w_run        = (r_state == ST_RUN);
  assign w_idx        = bus.pc[IDX_BITS+1:2] ^ IDX_BITS'(r_ghr);
  assign w_pred       = w_run && r_pht[w_idx][CTR_BITS-1];
  assign w_mispred    = bus.branch_resolved && (bus.actual_taken != bus.pred_takenMEM);
  // A branch squashed by a same-cycle mispredict must not pollute history.
  assign w_spec_shift = w_run && bus.branch_early && !w_mispred;

  generate
    if (GHR_BITS == 1) begin : g_ghr_one
      assign w_ghr_spec = w_pred;
      assign w_ghr_fix  = bus.actual_taken;
    end else begin : g_ghr_multi
      assign w_ghr_spec = {r_ghr[GHR_BITS-2:0], w_pred};
      assign w_ghr_fix  = {bus.ghr_ckptMEM[GHR_BITS-2:0], bus.actual_taken};
    end
  endgenerate

  always_comb begin
    bus.PC_Jump    = '0;
    bus.jump_taken = 1'b0;
    bus.flush      = FLUSH_NONE;
    if (w_mispred) begin
      bus.jump_taken = 1'b1;
      bus.flush      = FLUSH_ALL;
      bus.PC_Jump    = bus.actual_taken ? bus.targetMEM : bus.pcMEM + XLEN'(4);
    end else if (bus.jump_early || (bus.branch_early && w_pred)) begin
      bus.jump_taken = 1'b1;
      bus.flush      = FLUSH_IF;
      bus.PC_Jump    = bus.pc + bus.immID;
    end
  end

  assign bus.pht_index = w_idx;
  assign bus.ghr_ckpt  = r_ghr;
  assign bus.init_busy = !w_run;

  gshare_bpu_sat_counter #(.CTR_BITS(CTR_BITS)) u_sat (
    .i_ctr (r_pht[bus.pht_indexMEM]),
    .i_up  (bus.actual_taken),
    .o_ctr (w_trained)
  );

  // Single write port: the init sweep owns it until RUN, training afterwards.
  assign w_we    = !w_run || bus.branch_resolved;
  assign w_waddr = w_run ? bus.pht_indexMEM : r_init_cnt;
  assign w_wdata = w_run ? w_trained : c_WNT;

  always_ff @(posedge clk) begin
    if (w_we) r_pht[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
      r_ghr      <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_init_cnt <= r_init_cnt + 1'b1;
          if (r_init_cnt == c_LAST) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
      if (w_mispred)         r_ghr <= w_ghr_fix;
      else if (w_spec_shift) r_ghr <= w_ghr_spec;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_gshare_bpu.sv
// ============================================================================
// tb_gshare_bpu : directed, table-driven self-checking bench for gshare_bpu
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_gshare_bpu;
  localparam int XLEN = 32, IDX_BITS = 3, GHR_BITS = 3, CTR_BITS = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  gshare_bpu_if #(.XLEN(XLEN), .IDX_BITS(IDX_BITS), .GHR_BITS(GHR_BITS)) bus ();

  gshare_bpu #(
    .XLEN(XLEN), .IDX_BITS(IDX_BITS), .GHR_BITS(GHR_BITS), .CTR_BITS(CTR_BITS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic        act;
    logic [2:0]  idx;
    logic [2:0]  ckpt;
    logic        taken;
    logic [2:0]  spec;
  } row_t;

  row_t tbl [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.jump_early      = 1'b0;
    bus.branch_early    = 1'b0;
    bus.pc              = '0;
    bus.immID           = '0;
    bus.branch_resolved = 1'b0;
    bus.actual_taken    = 1'b0;
    bus.pht_indexMEM    = '0;
    bus.ghr_ckptMEM     = '0;
    bus.pred_takenMEM   = 1'b0;
    bus.pcMEM           = '0;
    bus.targetMEM       = '0;
  endtask

  task automatic resolve(input logic [2:0] idx, input logic act, input logic pred,
                         input logic [2:0] ckpt);
    clr();
    bus.branch_resolved = 1'b1;
    bus.actual_taken    = act;
    bus.pred_takenMEM   = pred;
    bus.pht_indexMEM    = idx;
    bus.ghr_ckptMEM     = ckpt;
    tick();
    clr();
  endtask

  task automatic sweep();
    for (int i = 0; i < 8; i++) begin
      chk("init_busy_sweep", 32'(bus.init_busy), 32'd1);
      tick();
    end
    chk("init_busy_done", 32'(bus.init_busy), 32'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_init_busy", 32'(bus.init_busy), 32'd1);
    chk("rst_ghr", 32'(bus.ghr_ckpt), 32'd0);
    chk("rst_jump_taken", 32'(bus.jump_taken), 32'd0);
    chk("rst_flush", 32'(bus.flush), 32'd0);
    chk("rst_pc_jump", bus.PC_Jump, 32'd0);
    chk("rst_pht_index", 32'(bus.pht_index), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic mis;
    // Hand-computed gshare training walk from GHR=0, all counters 01.
    tbl[0] = '{32'h10, 32'h20, 1'b1, 3'd4, 3'd0, 1'b0, 3'd0};
    tbl[1] = '{32'h10, 32'h20, 1'b1, 3'd5, 3'd1, 1'b0, 3'd2};
    tbl[2] = '{32'h10, 32'h20, 1'b1, 3'd7, 3'd3, 1'b0, 3'd6};
    tbl[3] = '{32'h10, 32'h20, 1'b1, 3'd3, 3'd7, 1'b0, 3'd6};
    tbl[4] = '{32'h10, 32'h20, 1'b1, 3'd3, 3'd7, 1'b1, 3'd7};

    clr();
    #2;
    chk_reset_outputs();
    tick();
    rst_n = 1'b1;
    sweep();

    // First prediction after the sweep
    bus.branch_early = 1'b1;
    bus.pc = 32'h10;
    #1;
    chk("first_pred_idx", 32'(bus.pht_index), 32'd4);
    chk("first_pred_taken", 32'(bus.jump_taken), 32'd0);
    tick();
    clr();

    // Predict/resolve rounds
    for (int r = 0; r < 5; r++) begin
      clr();
      bus.branch_early = 1'b1;
      bus.pc = tbl[r].pc;
      bus.immID = tbl[r].imm;
      #1;
      chk("tbl_idx", 32'(bus.pht_index), 32'(tbl[r].idx));
      chk("tbl_ckpt", 32'(bus.ghr_ckpt), 32'(tbl[r].ckpt));
      chk("tbl_taken", 32'(bus.jump_taken), 32'(tbl[r].taken));
      chk("tbl_flush", 32'(bus.flush), tbl[r].taken ? 32'd1 : 32'd0);
      if (tbl[r].taken) chk("tbl_pc_jump", bus.PC_Jump, tbl[r].pc + tbl[r].imm);
      tick();
      clr();
      bus.branch_resolved = 1'b1;
      bus.actual_taken  = tbl[r].act;
      bus.pht_indexMEM  = tbl[r].idx;
      bus.ghr_ckptMEM   = tbl[r].ckpt;
      bus.pred_takenMEM = tbl[r].taken;
      bus.pcMEM         = tbl[r].pc;
      bus.targetMEM     = tbl[r].pc + tbl[r].imm;
      #1;
      mis = tbl[r].act != tbl[r].taken;
      chk("tbl_spec_ghr", 32'(bus.ghr_ckpt), 32'(tbl[r].spec));
      chk("tbl_res_taken", 32'(bus.jump_taken), 32'(mis));
      chk("tbl_res_flush", 32'(bus.flush), mis ? 32'd3 : 32'd0);
      if (mis) chk("tbl_res_pc", bus.PC_Jump, tbl[r].act ? tbl[r].pc + tbl[r].imm : tbl[r].pc + 32'd4);
      tick();
    end
    clr();
    chk("tbl_final_ghr", 32'(bus.ghr_ckpt), 32'd7);

    // Saturation on index 0 (GHR=7, so pc 0x1C maps to index 0)
    for (int i = 0; i < 4; i++) resolve(3'd0, 1'b1, 1'b1, 3'd7);
    bus.branch_early = 1'b1; bus.pc = 32'h1C; bus.immID = 32'h20;
    #1;
    chk("sat_hi_idx", 32'(bus.pht_index), 32'd0);
    chk("sat_hi_taken", 32'(bus.jump_taken), 32'd1);
    chk("sat_hi_pc", bus.PC_Jump, 32'h3C);
    tick();
    for (int i = 0; i < 2; i++) resolve(3'd0, 1'b0, 1'b0, 3'd7);
    bus.branch_early = 1'b1; bus.pc = 32'h1C;
    #1;
    chk("sat_mid_taken", 32'(bus.jump_taken), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) resolve(3'd0, 1'b0, 1'b0, 3'd6);
    bus.branch_early = 1'b1; bus.pc = 32'h18;
    #1;
    chk("sat_lo_idx", 32'(bus.pht_index), 32'd0);
    chk("sat_lo_taken", 32'(bus.jump_taken), 32'd0);
    tick();
    clr();
    chk("sat_ghr", 32'(bus.ghr_ckpt), 32'd4);

    // Mispredict, not-taken side then taken side
    bus.branch_resolved = 1'b1; bus.pred_takenMEM = 1'b1; bus.actual_taken = 1'b0;
    bus.pcMEM = 32'h40; bus.targetMEM = 32'h80; bus.ghr_ckptMEM = 3'b101; bus.pht_indexMEM = 3'd6;
    #1;
    chk("mis_nt_taken", 32'(bus.jump_taken), 32'd1);
    chk("mis_nt_flush", 32'(bus.flush), 32'd3);
    chk("mis_nt_pc", bus.PC_Jump, 32'h44);
    tick();
    chk("mis_nt_ghr", 32'(bus.ghr_ckpt), 32'd2);
    bus.pred_takenMEM = 1'b0; bus.actual_taken = 1'b1; bus.ghr_ckptMEM = 3'b011;
    #1;
    chk("mis_t_pc", bus.PC_Jump, 32'h80);
    tick();
    clr();
    chk("mis_t_ghr", 32'(bus.ghr_ckpt), 32'd7);

    // Same-cycle ID branch (would predict taken at index 3) and mispredict
    bus.branch_early = 1'b1; bus.pc = 32'h10; bus.immID = 32'h20;
    bus.branch_resolved = 1'b1; bus.pred_takenMEM = 1'b1; bus.actual_taken = 1'b0;
    bus.pcMEM = 32'h40; bus.ghr_ckptMEM = 3'b001; bus.pht_indexMEM = 3'd2;
    #1;
    chk("prio_taken", 32'(bus.jump_taken), 32'd1);
    chk("prio_flush", 32'(bus.flush), 32'd3);
    chk("prio_pc", bus.PC_Jump, 32'h44);
    tick();
    clr();
    chk("prio_ghr", 32'(bus.ghr_ckpt), 32'd2);

    // JAL with PC wrap
    bus.jump_early = 1'b1; bus.pc = 32'hFFFF_FFF0; bus.immID = 32'h20;
    #1;
    chk("jal_taken", 32'(bus.jump_taken), 32'd1);
    chk("jal_flush", 32'(bus.flush), 32'd1);
    chk("jal_pc", bus.PC_Jump, 32'h10);
    tick();
    clr();
    chk("jal_ghr", 32'(bus.ghr_ckpt), 32'd2);

    // Reset mid-run; index 3 still holds 3 while the sweep has not reached it
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    tick();
    rst_n = 1'b1;
    bus.branch_early = 1'b1; bus.pc = 32'h0C; bus.immID = 32'h20;
    #1;
    chk("init_pred_taken", 32'(bus.jump_taken), 32'd0);
    tick();
    clr();
    chk("init_no_shift", 32'(bus.ghr_ckpt), 32'd0);
    tick();
    tick();
    // Reset mid-sweep
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    tick();
    rst_n = 1'b1;
    sweep();
    bus.branch_early = 1'b1; bus.pc = 32'h0C;
    #1;
    chk("reinit_idx", 32'(bus.pht_index), 32'd3);
    chk("reinit_taken", 32'(bus.jump_taken), 32'd0);
    tick();
    clr();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
